// File: rtl/core_pkg.sv
// core_pkg: shared core-wide widths, bubble constant and fetch-queue entry type
//   PC_W, INST_W : default PC and instruction widths
//   NOP_BUBBLE   : all-zero instruction shown to decode when nothing is queued
//   fq_entry_t   : one queued (pc, inst) pair
package core_pkg;
    localparam int PC_W = 13;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_BUBBLE = '0;
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode handshake bundle around the fetch queue
//   master : fetch + decode side (drives f_*, c_ready, flush)
//   slave  : queue side (drives f_ready, f_afull, c_*, count)
interface fetch_queue_if #(
    parameter int PC_W   = 13,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    logic                     f_valid;
    logic [PC_W-1:0]          f_pc;
    logic [INST_W-1:0]        f_inst;
    logic                     f_kill;
    logic                     f_ready;
    logic                     f_afull;
    logic                     c_valid;
    logic [PC_W-1:0]          c_pc;
    logic [INST_W-1:0]        c_inst;
    logic                     c_ready;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;
    modport master (
        output f_valid, f_pc, f_inst, f_kill, c_ready, flush,
        input  f_ready, f_afull, c_valid, c_pc, c_inst, count
    );
    modport slave (
        input  f_valid, f_pc, f_inst, f_kill, c_ready, flush,
        output f_ready, f_afull, c_valid, c_pc, c_inst, count
    );
endinterface

// File: rtl/fq_mem.sv
// fq_mem: DEPTH x W register array, synchronous write, asynchronous read, no reset
//   CLK     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module fq_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 45
) (
    input  logic                     CLK,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    always_ff @(posedge CLK) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry (pc, inst) queue between fetch and decode with flush and kill
//   CLK  : clock
//   NRST : synchronous active-low reset (same effect as flush)
//   bus  : fetch_queue_if slave (fetch enqueue side, decode dequeue side, flush, count)
module fetch_queue #(
    parameter int PC_W     = core_pkg::PC_W,
    parameter int INST_W   = core_pkg::INST_W,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input logic           CLK,
    input logic           NRST,
    fetch_queue_if.slave  bus
);
    import core_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic                   w_enq;
    logic                   w_deq;
    logic                   w_valid;
    logic [PC_W+INST_W-1:0] w_rdata;
    // Ready/valid come only from the registered count, so a full queue never
    // reuses a slot freed by a same-cycle dequeue.
    assign bus.f_ready = r_count < FULL_C;
    assign bus.f_afull = r_count >= AF_C;
    assign w_valid = r_count != '0;
    assign w_enq = bus.f_valid & bus.f_ready & ~bus.f_kill & ~bus.flush;
    assign w_deq = w_valid & bus.c_ready & ~bus.flush;
    assign bus.c_valid = w_valid;
    assign bus.c_pc = w_valid ? w_rdata[PC_W+INST_W-1:INST_W] : '0;
    assign bus.c_inst = w_valid ? w_rdata[INST_W-1:0] : INST_W'(NOP_BUBBLE);
    assign bus.count = r_count;
    always_ff @(posedge CLK) begin
        if (!NRST || bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + AW'(1);
            if (w_deq) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end
    fq_mem #(
        .DEPTH (DEPTH),
        .W     (PC_W + INST_W)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_enq),
        .i_waddr (r_wptr),
        .i_wdata ({bus.f_pc, bus.f_inst}),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a queue-based reference model for fetch_queue
module tb_fetch_queue;
    import core_pkg::*;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;
    fq_entry_t q[$];
    fetch_queue_if #(.PC_W(13), .INST_W(32), .DEPTH(4)) bus ();
    fetch_queue #(.PC_W(13), .INST_W(32), .DEPTH(4), .AF_LEVEL(3)) dut (
        .CLK  (clk),
        .NRST (nrst),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] inst_of(input logic [12:0] pc);
        return 32'hC0DE_0000 | {19'h0, pc};
    endfunction
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    task automatic step(input logic fv, input logic [12:0] pc, input logic kill, input logic cr, input logic fl);
        bus.f_valid = fv;
        bus.f_pc = pc;
        bus.f_inst = inst_of(pc);
        bus.f_kill = kill;
        bus.c_ready = cr;
        bus.flush = fl;
        @(posedge clk);
        #1;
    endtask
    // Reference: an ordered list of accepted entries, updated from the rules at each edge.
    always @(posedge clk) begin
        if (!nrst || bus.flush) begin
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            automatic bit full = q.size() == 4;
            automatic bit do_deq = q.size() > 0 && bus.c_ready;
            automatic bit do_enq = bus.f_valid && !full && !bus.f_kill;
            automatic fq_entry_t e;
            e.pc = bus.f_pc;
            e.inst = bus.f_inst;
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back(e);
        end
    end
    always @(negedge clk) begin
        if (model_ok) begin
            check("m_count", 64'(bus.count), 64'(q.size()));
            check("m_c_valid", 64'(bus.c_valid), 64'(q.size() != 0));
            check("m_c_pc", 64'(bus.c_pc), q.size() != 0 ? 64'(q[0].pc) : 64'h0);
            check("m_c_inst", 64'(bus.c_inst), q.size() != 0 ? 64'(q[0].inst) : 64'h0);
            check("m_f_ready", 64'(bus.f_ready), 64'(q.size() < 4));
            check("m_f_afull", 64'(bus.f_afull), 64'(q.size() >= 3));
        end
    end
    initial begin
        nrst = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_count", 64'(bus.count), 0);
        check("rst_c_valid", 64'(bus.c_valid), 0);
        check("rst_c_pc", 64'(bus.c_pc), 0);
        check("rst_c_inst", 64'(bus.c_inst), 0);
        check("rst_f_ready", 64'(bus.f_ready), 1);
        check("rst_f_afull", 64'(bus.f_afull), 0);
        nrst = 1'b1;
        step(1, 13'h000, 0, 0, 0);
        check("fill1_count", 64'(bus.count), 1);
        check("fill1_c_pc", 64'(bus.c_pc), 0);
        check("fill1_c_inst", 64'(bus.c_inst), 64'hC0DE_0000);
        step(1, 13'h004, 0, 0, 0);
        check("fill2_afull", 64'(bus.f_afull), 0);
        step(1, 13'h008, 0, 0, 0);
        check("fill3_afull", 64'(bus.f_afull), 1);
        check("fill3_ready", 64'(bus.f_ready), 1);
        step(1, 13'h00C, 0, 0, 0);
        check("fill4_count", 64'(bus.count), 4);
        check("fill4_ready", 64'(bus.f_ready), 0);
        step(0, 0, 0, 1, 0);
        check("drain1_pc", 64'(bus.c_pc), 64'h004);
        step(0, 0, 0, 1, 0);
        check("drain2_pc", 64'(bus.c_pc), 64'h008);
        step(0, 0, 0, 1, 0);
        check("drain3_pc", 64'(bus.c_pc), 64'h00C);
        check("drain3_inst", 64'(bus.c_inst), 64'hC0DE_000C);
        step(0, 0, 0, 1, 0);
        check("empty_valid", 64'(bus.c_valid), 0);
        check("empty_pc", 64'(bus.c_pc), 0);
        check("empty_inst", 64'(bus.c_inst), 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 13'(13'h100 + 4 * i), 0, 1, 0);
            check("wrap_pc", 64'(bus.c_pc), 64'(13'h100 + 4 * i));
            check("wrap_count", 64'(bus.count), 1);
        end
        step(0, 0, 0, 1, 0);
        step(1, 13'h200, 0, 0, 0);
        step(1, 13'h204, 0, 0, 0);
        step(1, 13'h208, 0, 1, 0);
        check("sim_count", 64'(bus.count), 2);
        check("sim_head1", 64'(bus.c_pc), 64'h204);
        step(1, 13'h20C, 0, 1, 0);
        check("sim_head2", 64'(bus.c_pc), 64'h208);
        step(1, 13'h210, 0, 1, 0);
        check("sim_head3", 64'(bus.c_pc), 64'h20C);
        step(1, 13'h214, 0, 1, 0);
        check("sim_fifth", 64'(bus.c_pc), 64'h210);
        check("sim_count2", 64'(bus.count), 2);
        step(1, 13'h300, 0, 0, 0);
        check("pre_flush_count", 64'(bus.count), 3);
        step(1, 13'h304, 0, 1, 1);
        check("flush_count", 64'(bus.count), 0);
        check("flush_valid", 64'(bus.c_valid), 0);
        step(1, 13'h308, 0, 0, 0);
        check("post_flush_pc", 64'(bus.c_pc), 64'h308);
        check("post_flush_count", 64'(bus.count), 1);
        step(0, 0, 0, 1, 0);
        step(1, 13'h400, 0, 0, 0);
        step(1, 13'h404, 1, 0, 0);
        check("kill_count", 64'(bus.count), 1);
        check("kill_ready", 64'(bus.f_ready), 1);
        step(1, 13'h408, 0, 0, 0);
        check("kill_count2", 64'(bus.count), 2);
        check("kill_headA", 64'(bus.c_pc), 64'h400);
        step(0, 0, 0, 1, 0);
        check("kill_headC", 64'(bus.c_pc), 64'h408);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 13'(13'h500 + 4 * i), 0, 0, 0);
        step(1, 13'h510, 0, 1, 0);
        check("fulldeq_count", 64'(bus.count), 3);
        check("fulldeq_head", 64'(bus.c_pc), 64'h504);
        step(1, 13'h514, 0, 0, 0);
        check("fulldeq_refill", 64'(bus.count), 4);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("fulldeq_last", 64'(bus.c_pc), 64'h514);
        step(1, 13'h600, 0, 0, 0);
        nrst = 1'b0;
        step(1, 13'h604, 0, 1, 0);
        check("midrst_count", 64'(bus.count), 0);
        check("midrst_valid", 64'(bus.c_valid), 0);
        nrst = 1'b1;
        step(1, 13'h608, 0, 0, 0);
        check("postrst_pc", 64'(bus.c_pc), 64'h608);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue between the fetch stage and the decode stage of the RV32I core, replacing the single-entry fetch/decode pipeline register. It buffers up to DEPTH (pc, instruction) pairs with valid/ready handshakes on both sides, so a decode stall no longer freezes fetch immediately. It discards all contents on a branch mispredict flush and can squash the incoming instruction on a predicted-taken redirect. When empty, it presents an all-zero bubble to decode.

## Interface
- PC_W, 13, PC width in bits
- INST_W, 32, instruction width in bits
- DEPTH, 4, number of entries; power of two, at least 2
- AF_LEVEL, DEPTH-1, occupancy at or above which `f_afull` asserts; range 1..DEPTH

- CLK  in  1  clock; all state updates on the rising edge
- NRST  in  1  reset, synchronous, active-low
- f_valid  in  1  fetch presents an instruction
- f_pc  in  PC_W  fetch PC
- f_inst  in  INST_W  fetch instruction word
- f_kill  in  1  squash the instruction presented this cycle (predicted-taken redirect)
- f_ready  out  1  queue can accept; equals `count < DEPTH`
- f_afull  out  1  `count >= AF_LEVEL`; fetch throttle hint
- c_valid  out  1  head entry valid for decode
- c_pc  out  PC_W  head PC; 0 when `c_valid` is 0
- c_inst  out  INST_W  head instruction; 0 when `c_valid` is 0
- c_ready  in  1  decode consumes the head this cycle; the inverse of the old stall
- flush  in  1  mispredict; discard every entry
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Enqueue condition: `enq = f_valid & f_ready & ~f_kill & ~flush`.
  - The write goes to `mem[wptr]`, then `wptr` increments.
- Dequeue condition: `deq = c_valid & c_ready & ~flush`.
  - `rptr` increments.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- Count update:
  - `count` becomes `count + enq - deq`.
  - Simultaneous enq and deq leaves `count` unchanged.
  - Both are legal in the same cycle at any occupancy below DEPTH.
- Full behaviour: when `count == DEPTH`, `f_ready` is 0 and `f_valid` is ignored, even if decode dequeues in the same cycle. There is no same-cycle reuse of a freed slot.
- Empty behaviour: when `count == 0`, `c_valid`, `c_pc` and `c_inst` are 0. `c_ready` is ignored.
- `f_kill` drops only the instruction presented in that cycle. Queued entries are untouched and `f_ready` is unaffected.
- Flush has the highest priority, after reset:
  - `rptr`, `wptr` and `count` go to 0.
  - The enqueue and dequeue in that cycle are discarded.
- Reset (NRST=0 at an edge) has the same effect as flush. Memory contents need not be cleared.
- Reset values:
  - `count` = 0
  - `c_valid` = 0
  - `c_pc` = 0
  - `c_inst` = 0
  - `f_ready` = 1
  - `f_afull` = 0 when AF_LEVEL > 0
- No combinational path runs from `c_ready` to `f_ready`, or from `f_valid` to `c_valid`.

## Timing
- Latency: an entry enqueued at edge N is visible on `c_valid`/`c_pc`/`c_inst` after edge N, i.e. in the next cycle. There is no same-cycle bypass.
- All outputs are functions of registered state only (pointers, count, memory).
- Throughput: one enqueue and one dequeue per cycle sustained.
- Flush asserted in cycle N: the queue is empty in cycle N+1. An `f_valid` in cycle N+1 is accepted normally.
- Mid-operation reset behaves identically to flush. There is no partial state after it.

## Structure
- Shared package `core_pkg`:
  - `PC_W` and `INST_W` defaults
  - `NOP_BUBBLE` constant (all-zero instruction)
  - `fq_entry_t` struct {pc, inst}
- One sub-module, `fq_mem`: a DEPTH x (PC_W+INST_W) register array.
  - Synchronous write port.
  - Asynchronous read port.
  - No reset on storage.
- Pointer, count and flush logic live in `fetch_queue`.

## Test plan
- **Reset, then fill:** hold NRST=0 for 2 cycles, then enqueue pc=0x000,0x004,0x008,0x00C with `c_ready`=0.
  - `count` reaches 4 and `f_ready` drops to 0 after the 4th edge.
  - `f_afull` asserts when `count` reaches 3.
- **Drain in order and wrap:** from the full state, raise `c_ready` for 4 cycles.
  - `c_pc` reads 0x000, 0x004, 0x008, 0x00C, then `c_valid`=0 with `c_pc`=0 and `c_inst`=0.
  - Then do 6 more enq/deq pairs to cross the pointer wrap; order is preserved.
- **Simultaneous enq/deq at count 2:**
  - `count` stays 2 and the head advances by one entry per cycle.
  - The 5th accepted instruction appears exactly 2 cycles after its enqueue.
- **Flush with 3 entries while `f_valid`=1 and `c_ready`=1:**
  - Next cycle `count`=0 and `c_valid`=0.
  - The flush-cycle instruction is never delivered.
  - An instruction presented the following cycle is delivered next.
- **Kill:** enqueue A, then present B with `f_kill`=1, then C.
  - Decode receives A then C.
  - `count` never exceeds 2.
- **Full with dequeue:** at count=DEPTH, assert `f_valid`=1 and `c_ready`=1.
  - `f_valid` is ignored and `count` becomes DEPTH-1.
  - An enqueue is accepted the following cycle.
